fsum_reducer: RTL and testbench



---
 rtl/fsum_reducer_pkg.sv | 13 +
 rtl/fsum_reducer_if.sv | 25 ++
 rtl/fsum_pair_select.sv | 20 ++
 rtl/fsum_reducer.sv | 82 ++++++++
 tb/tb_fsum_reducer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/fsum_reducer_pkg.sv
// fsum_reducer_pkg: shared types, constants and helpers for the FP vector reducer.
package fsum_reducer_pkg;
    localparam int FLOAT_SIZE   = 32;
    localparam int ADDER_DELAY  = 4;
    localparam int FSUM_LATENCY = ADDER_DELAY;

    typedef enum logic [1:0] {ACCUM, DRAIN, OUT} fsum_state_t;

    // True for +0 and -0: the sign bit is shifted out, so exponent and mantissa must both be zero.
    function automatic logic is_fzero(input logic [FLOAT_SIZE-1:0] f);
        return (f << 1) == '0;
    endfunction
endpackage

// File: rtl/fsum_reducer_if.sv
// fsum_reducer_if: input stream, adder issue/result and sum output channels of fsum_reducer.
interface fsum_reducer_if;
    import fsum_reducer_pkg::*;
    logic                  s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [FLOAT_SIZE-1:0] s_axis_tdata;
    logic                  m_add_tvalid;
    logic [FLOAT_SIZE-1:0] m_add_a_tdata, m_add_b_tdata;
    logic                  s_add_result_tvalid;
    logic [FLOAT_SIZE-1:0] s_add_result_tdata;
    logic                  m_axis_sum_tvalid, m_axis_sum_tready;
    logic [FLOAT_SIZE-1:0] m_axis_sum_tdata;

    modport master (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_add_result_tvalid,
               s_add_result_tdata, m_axis_sum_tready,
        output s_axis_tready, m_add_tvalid, m_add_a_tdata, m_add_b_tdata,
               m_axis_sum_tvalid, m_axis_sum_tdata
    );
    modport slave (
        output s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_add_result_tvalid,
               s_add_result_tdata, m_axis_sum_tready,
        input  s_axis_tready, m_add_tvalid, m_add_a_tdata, m_add_b_tdata,
               m_axis_sum_tvalid, m_axis_sum_tdata
    );
endinterface

// File: rtl/fsum_pair_select.sv
// fsum_pair_select: picks at most one adder pair from {hold, result, input}; the leftover goes to hold.
module fsum_pair_select import fsum_reducer_pkg::*; (
    input  logic                  h_valid, r_valid, i_valid,
    input  logic [FLOAT_SIZE-1:0] h_data, r_data, i_data,
    output logic                  issue, nh_valid,
    output logic [FLOAT_SIZE-1:0] a, b, nh_data
);
    logic hr, hi, ri;

    always_comb begin
        hr = h_valid && r_valid;
        hi = h_valid && i_valid && !r_valid;
        ri = r_valid && i_valid && !h_valid;
        issue = hr || hi || ri;
        a = (hr || hi) ? h_data : r_data;
        b = hr ? r_data : i_data;
        nh_valid = hr ? i_valid : !issue && (h_valid || r_valid || i_valid);
        nh_data = !nh_valid ? '0 : !issue && h_valid ? h_data : !issue && r_valid ? r_data : i_data;
    end
endmodule

// File: rtl/fsum_reducer.sv
// fsum_reducer: streaming FP vector sum that recirculates a fixed-latency adder's results.
// Optional macro FSUM_ZERO_SKIP_EN keeps +/-0 elements out of the reduction pool.
module fsum_reducer import fsum_reducer_pkg::*; #(
    parameter int LATENCY = FSUM_LATENCY,
    parameter int CNT_W   = 16
) (
    input logic            aclk,
    input logic            reset,
    fsum_reducer_if.master bus
);
    localparam int IW = $clog2(LATENCY + 2);

    fsum_state_t           state;
    logic                  h_valid, nh_valid, issue, accept, i_valid, r_valid, ready;
    logic [FLOAT_SIZE-1:0] h_data, nh_data, a, b;
    logic [IW-1:0]         inflight, blank;
    logic [CNT_W-1:0]      count;

    assign ready                 = state == ACCUM && blank == '0;
    assign bus.s_axis_tready     = ready;
    assign bus.m_axis_sum_tvalid = state == OUT;
    assign accept                = bus.s_axis_tvalid && ready;
`ifdef FSUM_ZERO_SKIP_EN
    assign i_valid = accept && !is_fzero(bus.s_axis_tdata);
`else
    assign i_valid = accept;
`endif
    // The adder is not reset, so its output is untrusted until its pipeline has flushed.
    assign r_valid = bus.s_add_result_tvalid && blank == '0 && inflight != '0;

    fsum_pair_select u_sel (
        .h_valid (h_valid),
        .r_valid (r_valid),
        .i_valid (i_valid),
        .h_data  (h_data),
        .r_data  (bus.s_add_result_tdata),
        .i_data  (bus.s_axis_tdata),
        .issue   (issue),
        .nh_valid(nh_valid),
        .a       (a),
        .b       (b),
        .nh_data (nh_data)
    );

    always_ff @(posedge aclk) begin
        if (reset) begin
            state                <= ACCUM;
            h_valid              <= 1'b0;
            h_data               <= '0;
            inflight             <= '0;
            blank                <= IW'(LATENCY + 1);
            count                <= '0;
            bus.m_add_tvalid     <= 1'b0;
            bus.m_add_a_tdata    <= '0;
            bus.m_add_b_tdata    <= '0;
            bus.m_axis_sum_tdata <= '0;
        end else begin
            bus.m_add_tvalid <= issue;
            if (issue) begin
                bus.m_add_a_tdata <= a;
                bus.m_add_b_tdata <= b;
            end
            inflight <= inflight + IW'(issue) - IW'(r_valid);
            blank    <= blank - IW'(blank != '0);
            h_valid  <= nh_valid;
            h_data   <= nh_data;
            if (accept) count <= count + CNT_W'(1);
            if (accept && bus.s_axis_tlast) state <= DRAIN;
            // With nothing in flight the hold register is the final sum (zero when empty).
            if (state == DRAIN && inflight == '0) begin
                state                <= OUT;
                bus.m_axis_sum_tdata <= h_data;
                h_valid              <= 1'b0;
                h_data               <= '0;
            end
            if (state == OUT && bus.m_axis_sum_tready) begin
                state <= ACCUM;
                count <= '0;
            end
        end
    end
endmodule

// File: tb/tb_fsum_reducer.sv
// tb_fsum_reducer: table, hand-written and random vectors checked against an integer-valued FP32 sum model.
module tb_fsum_reducer;
    localparam int L = 4;
`ifdef FSUM_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct {
        int               n;
        logic [0:7][31:0] d;
        logic [31:0]      sum;
        int               iss;
        int               lat;
        int               hold;
    } vec_t;

    logic aclk, reset;
    int tests = 0, fails = 0, issues = 0;
    logic [31:0] vec [0:15];
    vec_t tbl [7];
    bit pipe_v [0:L];
    logic [31:0] pipe_d [0:L];

    fsum_reducer_if bus ();

    fsum_reducer #(.LATENCY(L), .CNT_W(16)) dut (
        .aclk (aclk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    function automatic int f2i(input logic [31:0] f);
        int e = int'(f[30:23]) - 127;
        int m = int'({1'b1, f[22:0]});
        int v;
        if (f[30:23] == 8'd0) return 0;
        v = (e >= 23) ? (m << (e - 23)) : (e < 0 ? 0 : (m >> (23 - e)));
        return f[31] ? -v : v;
    endfunction

    function automatic logic [31:0] i2f(input int v);
        int m = (v < 0) ? -v : v;
        int e = 0;
        if (v == 0) return 32'h0;
        for (int k = 0; k < 24; k++) if ((m >> k) != 0) e = k;
        return {v < 0, 8'(e + 127), 23'((m << (23 - e)) & 32'h7FFFFF)};
    endfunction

    // Adder model: pair presented in cycle c returns in cycle c+L; never reset.
    always @(negedge aclk) begin
        for (int k = L; k > 0; k--) begin
            pipe_v[k] = pipe_v[k-1];
            pipe_d[k] = pipe_d[k-1];
        end
        pipe_v[0] = bus.m_add_tvalid === 1'b1;
        pipe_d[0] = i2f(f2i(bus.m_add_a_tdata) + f2i(bus.m_add_b_tdata));
        if (pipe_v[0]) issues++;
        bus.s_add_result_tvalid = pipe_v[L];
        bus.s_add_result_tdata  = pipe_d[L];
    end

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic blank_check(input string name);
        for (int k = 0; k <= L; k++) begin
            check({name, "_blank_rdy"}, bus.s_axis_tready, 0);
            step();
        end
        check({name, "_open_rdy"}, bus.s_axis_tready, 1);
    endtask

    task automatic await_sum(input string name, input logic [31:0] exp, input int exp_iss,
                             input int iss0, input int hold, output int waited);
        waited = 0;
        while (!bus.m_axis_sum_tvalid && waited < 300) begin
            step();
            waited++;
        end
        check({name, "_valid"}, bus.m_axis_sum_tvalid, 1);
        check({name, "_sum"}, bus.m_axis_sum_tdata, exp);
        for (int k = 0; k < hold; k++) begin
            step();
            check({name, "_hold_valid"}, bus.m_axis_sum_tvalid, 1);
            check({name, "_hold_sum"}, bus.m_axis_sum_tdata, exp);
            check({name, "_hold_rdy"}, bus.s_axis_tready, 0);
        end
        bus.m_axis_sum_tready = 1'b1;
        step();
        bus.m_axis_sum_tready = 1'b0;
        check({name, "_released"}, bus.m_axis_sum_tvalid, 0);
        check({name, "_issues"}, issues - iss0, exp_iss);
    endtask

    task automatic run_vector(input string name, input int n, input bit gaps, input logic [31:0] exp,
                              input int exp_iss, input int exp_lat, input int hold);
        int i = 0, guard = 0, iss0 = issues, waited;
        bit acc;
        bus.m_axis_sum_tready = 1'b0;
        while (i < n && guard < 500) begin
            bus.s_axis_tvalid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.s_axis_tdata  = vec[i];
            bus.s_axis_tlast  = (i == n - 1);
            acc = bus.s_axis_tvalid && bus.s_axis_tready;
            step();
            guard++;
            if (acc) i++;
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        check({name, "_accepted"}, i, n);
        await_sum(name, exp, exp_iss, iss0, hold, waited);
        if (exp_lat >= 0) check({name, "_latency"}, waited + 1, exp_lat);
    endtask

    initial begin
        bit pv [7];
        logic [31:0] pd [7];
        int iss0, waited, n, s, pooled, v;

        tbl[0] = '{n:4, d:{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 128'h0},
                   sum:32'h41200000, iss:3, lat:-1, hold:0};
        tbl[1] = '{n:1, d:{32'h3F800000, 224'h0}, sum:32'h3F800000, iss:0, lat:2, hold:0};
        tbl[2] = '{n:8, d:{8{32'h3F800000}}, sum:32'h41000000, iss:7, lat:-1, hold:0};
        tbl[3] = '{n:1, d:{32'h80000000, 224'h0}, sum:(SKIP ? 32'h0 : 32'h80000000), iss:0, lat:2, hold:0};
        tbl[4] = '{n:3, d:{32'h0, 32'h40000000, 32'h0, 160'h0}, sum:32'h40000000,
                   iss:(SKIP ? 0 : 2), lat:-1, hold:0};
        tbl[5] = '{n:2, d:{32'h40000000, 32'h40000000, 192'h0}, sum:32'h40800000, iss:1, lat:L + 3, hold:0};
        tbl[6] = '{n:2, d:{32'h3F800000, 32'h40000000, 192'h0}, sum:32'h40400000, iss:1, lat:-1, hold:10};

        reset = 1'b1;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata = '0;
        bus.s_axis_tlast = 1'b0;
        bus.m_axis_sum_tready = 1'b0;
        repeat (3) step();
        check("rst_tready", bus.s_axis_tready, 0);
        check("rst_add_valid", bus.m_add_tvalid, 0);
        check("rst_add_a", bus.m_add_a_tdata, 0);
        check("rst_add_b", bus.m_add_b_tdata, 0);
        check("rst_sum_valid", bus.m_axis_sum_tvalid, 0);
        check("rst_sum_data", bus.m_axis_sum_tdata, 0);
        reset = 1'b0;
        blank_check("init");

        for (int t = 0; t < 7; t++) begin
            for (int k = 0; k < tbl[t].n; k++) vec[k] = tbl[t].d[k];
            run_vector($sformatf("tbl%0d", t), tbl[t].n, 1'b0, tbl[t].sum, tbl[t].iss, tbl[t].lat, tbl[t].hold);
        end

        // Result of the first pair returns in the same cycle as a new input while hold is occupied.
        pv = '{1, 1, 0, 0, 0, 1, 1};
        pd = '{32'h3F800000, 32'h3F800000, 0, 0, 0, 32'h3F800000, 32'h40800000};
        iss0 = issues;
        for (int k = 0; k < 7; k++) begin
            bus.s_axis_tvalid = pv[k];
            bus.s_axis_tdata  = pd[k];
            bus.s_axis_tlast  = (k == 6);
            check("coll_rdy", bus.s_axis_tready, 1);
            step();
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        check("coll_issue", bus.m_add_tvalid, 1);
        check("coll_a_is_hold", bus.m_add_a_tdata, 32'h3F800000);
        check("coll_b_is_result", bus.m_add_b_tdata, 32'h40000000);
        await_sum("coll", 32'h40E00000, 3, iss0, 0, waited);

        // Reset while draining with two adds outstanding; their late results must be ignored.
        for (int k = 0; k < 4; k++) begin
            bus.s_axis_tvalid = 1'b1;
            bus.s_axis_tdata  = i2f(k + 1);
            bus.s_axis_tlast  = (k == 3);
            check("drst_rdy", bus.s_axis_tready, 1);
            step();
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        check("drst_draining", bus.m_axis_sum_tvalid, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("drst_add_valid", bus.m_add_tvalid, 0);
        check("drst_sum_valid", bus.m_axis_sum_tvalid, 0);
        check("drst_sum_data", bus.m_axis_sum_tdata, 0);
        blank_check("drst");
        vec[0] = 32'h40000000;
        vec[1] = 32'h40000000;
        run_vector("drst_next", 2, 1'b0, 32'h40800000, 1, L + 3, 0);

        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(1, 12);
            s = 0;
            pooled = 0;
            for (int k = 0; k < n; k++) begin
                v = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 20));
                if ($urandom_range(0, 1) == 1) v = -v;
                vec[k] = i2f(v);
                s += v;
                if (!SKIP || v != 0) pooled++;
            end
            run_vector($sformatf("rnd%0d", r), n, 1'b1, i2f(s), (pooled > 0) ? pooled - 1 : 0, -1,
                       $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
